// File: rtl/uart_cmd_responder_pkg.sv
// Shared byte constants and FSM state encoding for the UART command responder.
package uart_cmd_responder_pkg;

  localparam logic [7:0] SOF    = 8'hAA;
  localparam logic [7:0] CMD_WR = 8'h57;
  localparam logic [7:0] CMD_RD = 8'h52;
  localparam logic [7:0] ACK    = 8'h06;
  localparam logic [7:0] NAK    = 8'h15;

  localparam int NUM_REGS = 16;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_GET_CMD,
    ST_GET_ADDR,
    ST_GET_DATA,
    ST_GET_CHK,
    ST_EXEC,
    ST_TX_LOAD,
    ST_TX_WAIT_HI,
    ST_TX_WAIT_LO
  } state_t;

endpackage

// File: rtl/uart_cmd_timeout.sv
// Inter-byte timeout: reloadable down-counter that strobes expire when it runs out.
module uart_cmd_timeout #(
  parameter int unsigned TIMEOUT_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic run,
  output logic expire
);

  localparam int unsigned CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] LOAD_VAL = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = LOAD_VAL;
    end else if (run && (cnt_q != '0)) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // A byte arriving on the expiry cycle wins over the timeout.
  assign expire = run && !load && (cnt_q == '0);

endmodule

// File: rtl/uart_cmd_responder.sv
// Byte-framed register read/write responder sitting between a UART RX and TX.
// Define UART_CMD_CHECKSUM_EN to require a checksum byte per frame and append one to reads.
module uart_cmd_responder
  import uart_cmd_responder_pkg::*;
#(
  parameter int unsigned CLK_FREQ       = 50000000,
  parameter int unsigned TIMEOUT_CYCLES = 500000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         rx_byte_ready,
  input  logic [7:0]   rx_byte,
  output logic [7:0]   tx_data_out,
  output logic         tx_start_out,
  input  logic         tx_busy_in,
  output logic [127:0] regs_flat,
  output logic         err_pulse
);

  if (CLK_FREQ == 0 || TIMEOUT_CYCLES < 2) begin : g_cfg_check
    $error("uart_cmd_responder: CLK_FREQ must be nonzero and TIMEOUT_CYCLES at least 2");
  end

`ifdef UART_CMD_CHECKSUM_EN
  localparam state_t ST_AFTER_PAYLOAD = ST_GET_CHK;
`else
  localparam state_t ST_AFTER_PAYLOAD = ST_EXEC;
`endif

  state_t          state_q, state_d;
  logic [7:0]      cmd_q, cmd_d;
  logic [7:0]      addr_q, addr_d;
  logic [7:0]      data_q, data_d;
  logic [2:0][7:0] resp_buf_q, resp_buf_d;
  logic [1:0]      resp_len_q, resp_len_d;
  logic [1:0]      resp_idx_q, resp_idx_d;

  logic       in_get, in_busy, rx_take, sof_hit, tmo_expire;
  logic       is_write, chk_ok, frame_valid, wr_en, more_resp;
  logic [7:0] rd_data;

  assign in_get   = state_q inside {ST_GET_CMD, ST_GET_ADDR, ST_GET_DATA, ST_GET_CHK};
  assign in_busy  = state_q inside {ST_EXEC, ST_TX_LOAD, ST_TX_WAIT_HI, ST_TX_WAIT_LO};
  assign rx_take  = rx_byte_ready && in_get;
  assign sof_hit  = (state_q == ST_IDLE) && rx_byte_ready && (rx_byte == SOF);
  assign is_write = (cmd_q == CMD_WR);

`ifdef UART_CMD_CHECKSUM_EN
  logic [7:0] chk_q, chk_d;
  // data_q is forced to zero for non-write frames, so reads check CMD ^ ADDR ^ 0.
  assign chk_ok = (chk_q == (cmd_q ^ addr_q ^ data_q));
`else
  assign chk_ok = 1'b1;
`endif

  assign frame_valid = (is_write || (cmd_q == CMD_RD)) && (addr_q[7:4] == 4'h0) && chk_ok;
  assign wr_en       = (state_q == ST_EXEC) && frame_valid && is_write;
  assign rd_data     = regs_flat[{addr_q[3:0], 3'b000} +: 8];
  assign more_resp   = ((resp_idx_q + 2'd1) != resp_len_q);

  uart_cmd_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk   (clk),
    .rst   (rst),
    .load  (rx_take || sof_hit),
    .run   (in_get),
    .expire(tmo_expire)
  );

  genvar gi;
  for (gi = 0; gi < NUM_REGS; gi++) begin : g_reg
    logic [7:0] reg_q, reg_d;

    always_comb begin
      reg_d = reg_q;
      if (wr_en && (addr_q[3:0] == 4'(gi))) begin
        reg_d = data_q;
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        reg_q <= 8'h00;
      end else begin
        reg_q <= reg_d;
      end
    end

    assign regs_flat[8*gi +: 8] = reg_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:       if (sof_hit) state_d = ST_GET_CMD;
      ST_GET_CMD: begin
        if (rx_byte_ready)   state_d = ST_GET_ADDR;
        else if (tmo_expire) state_d = ST_IDLE;
      end
      ST_GET_ADDR: begin
        if (rx_byte_ready)   state_d = is_write ? ST_GET_DATA : ST_AFTER_PAYLOAD;
        else if (tmo_expire) state_d = ST_IDLE;
      end
      ST_GET_DATA: begin
        if (rx_byte_ready)   state_d = ST_AFTER_PAYLOAD;
        else if (tmo_expire) state_d = ST_IDLE;
      end
      ST_GET_CHK: begin
        if (rx_byte_ready)   state_d = ST_EXEC;
        else if (tmo_expire) state_d = ST_IDLE;
      end
      ST_EXEC:       state_d = ST_TX_LOAD;
      ST_TX_LOAD:    if (!tx_busy_in) state_d = ST_TX_WAIT_HI;
      ST_TX_WAIT_HI: if (tx_busy_in) state_d = ST_TX_WAIT_LO;
      ST_TX_WAIT_LO: if (!tx_busy_in) state_d = more_resp ? ST_TX_LOAD : ST_IDLE;
      default:       state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    cmd_d      = cmd_q;
    addr_d     = addr_q;
    data_d     = data_q;
    resp_buf_d = resp_buf_q;
    resp_len_d = resp_len_q;
    resp_idx_d = resp_idx_q;
`ifdef UART_CMD_CHECKSUM_EN
    chk_d      = chk_q;
`endif
    if (rx_take) begin
      unique case (state_q)
        ST_GET_CMD:  cmd_d = rx_byte;
        ST_GET_ADDR: begin
          addr_d = rx_byte;
          data_d = 8'h00;
        end
        ST_GET_DATA: data_d = rx_byte;
`ifdef UART_CMD_CHECKSUM_EN
        ST_GET_CHK:  chk_d = rx_byte;
`endif
        default: ;
      endcase
    end

    if (state_q == ST_EXEC) begin
      resp_idx_d = 2'd0;
      if (!frame_valid) begin
        resp_buf_d[0] = NAK;
        resp_len_d    = 2'd1;
      end else if (is_write) begin
        resp_buf_d[0] = ACK;
        resp_len_d    = 2'd1;
      end else begin
        resp_buf_d[0] = ACK;
        resp_buf_d[1] = rd_data;
`ifdef UART_CMD_CHECKSUM_EN
        resp_buf_d[2] = rd_data ^ ACK;
        resp_len_d    = 2'd3;
`else
        resp_len_d    = 2'd2;
`endif
      end
    end

    if ((state_q == ST_TX_WAIT_LO) && !tx_busy_in && more_resp) begin
      resp_idx_d = resp_idx_q + 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cmd_q      <= 8'h00;
      addr_q     <= 8'h00;
      data_q     <= 8'h00;
      resp_buf_q <= '0;
      resp_len_q <= 2'd0;
      resp_idx_q <= 2'd0;
`ifdef UART_CMD_CHECKSUM_EN
      chk_q      <= 8'h00;
`endif
    end else begin
      cmd_q      <= cmd_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      resp_buf_q <= resp_buf_d;
      resp_len_q <= resp_len_d;
      resp_idx_q <= resp_idx_d;
`ifdef UART_CMD_CHECKSUM_EN
      chk_q      <= chk_d;
`endif
    end
  end

  // Outputs are gated by rst so an abort takes effect in the reset cycle itself.
  always_comb begin
    tx_start_out = 1'b0;
    tx_data_out  = 8'h00;
    err_pulse    = 1'b0;
    if (!rst) begin
      if (state_q inside {ST_TX_LOAD, ST_TX_WAIT_HI, ST_TX_WAIT_LO}) begin
        tx_data_out = resp_buf_q[resp_idx_q];
      end
      tx_start_out = (state_q == ST_TX_LOAD) && !tx_busy_in;
      err_pulse    = tmo_expire
                  || (rx_byte_ready && in_busy)
                  || ((state_q == ST_EXEC) && !frame_valid);
    end
  end

endmodule
